matrix_alu_seq: RTL and testbench

MATRIX_ALU_SEQ -- requirements
Module: matrix_alu_seq

---
 rtl/matrix_alu_seq.sv | 186 ++++++++++++++++++
 tb/tb_matrix_alu_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_alu_seq.sv
// Sequential N x N matrix ALU: two source registers, a staging buffer filled
// row-by-row (or element-by-element for MULTIPLY), and a result register that
// is only updated with a complete result.
// Optional build macro: MATRIX_ALU_SAT_EN -- saturate result elements instead
// of wrapping to the low W bits.
module matrix_alu_seq #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic               Clk,
  input  logic               nReset,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [N*N*W-1:0]   wr_data,
  input  logic               cmd_valid,
  input  logic [2:0]         cmd_op,
  input  logic [W-1:0]       cmd_imm,
  output logic               cmd_ready,
  input  logic               rd_en,
  output logic [N*N*W-1:0]   rd_data,
  output logic               rd_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int EW = N*N*W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2*W + IW + 1;

`ifdef MATRIX_ALU_SAT_EN
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [2:0] {
    OP_MUL = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2,
    OP_TRN = 3'd3, OP_SCL = 3'd4, OP_SCI = 3'd5
  } op_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [W-1:0]    imm_q, imm_d;
  logic [IW-1:0]   i_q, i_d, j_q, j_d;
  logic [EW-1:0]   src1_q, src1_d, src2_q, src2_d;
  logic [EW-1:0]   stage_q, stage_d, result_q, result_d;
  logic [EW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d, err_q, err_d;

  logic signed [PW-1:0] acc;
  int unsigned          ri, cj;

  function automatic logic signed [PW-1:0] elem(input logic [EW-1:0] m,
                                                input int unsigned r,
                                                input int unsigned c);
    return PW'(signed'(m[(r*N + c)*W +: W]));
  endfunction

  function automatic logic [W-1:0] reduce_elem(input logic signed [PW-1:0] v);
`ifdef MATRIX_ALU_SAT_EN
    if (v > SAT_MAX) return W'(SAT_MAX);
    if (v < SAT_MIN) return W'(SAT_MIN);
`endif
    return W'(v);
  endfunction

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == EXEC);
  assign done      = (state_q == DONE);
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;

  // State, sources, staging, result and read-port registers
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      op_q       <= OP_MUL;
      imm_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      stage_q    <= '0;
      result_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      imm_q      <= imm_d;
      i_q        <= i_d;
      j_q        <= j_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      stage_q    <= stage_d;
      result_q   <= result_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Next-state, datapath and request handling
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    imm_d      = imm_q;
    i_d        = i_q;
    j_d        = j_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    stage_d    = stage_q;
    result_d   = result_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    acc        = '0;
    ri         = 32'(i_q);
    cj         = 32'(j_q);

    if (wr_en) begin
      if (state_q == EXEC) err_d = 1'b1;
      else if (wr_sel)     src2_d = wr_data;
      else                 src1_d = wr_data;
    end

    if (rd_en) begin
      rd_data_d  = result_q;
      rd_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op <= 3'd5) begin
            state_d = EXEC;
            op_d    = op_t'(cmd_op);
            imm_d   = cmd_imm;
            i_d     = '0;
            j_d     = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (op_q == OP_MUL) begin
          for (int unsigned k = 0; k < N; k++)
            acc = acc + elem(src1_q, ri, k) * elem(src2_q, k, cj);
          stage_d[(ri*N + cj)*W +: W] = reduce_elem(acc);
        end else begin
          for (int unsigned j = 0; j < N; j++) begin
            case (op_q)
              OP_ADD:  acc = elem(src1_q, ri, j) + elem(src2_q, ri, j);
              OP_SUB:  acc = elem(src1_q, ri, j) - elem(src2_q, ri, j);
              OP_TRN:  acc = elem(src1_q, j, ri);
              OP_SCL:  acc = elem(src1_q, ri, j) * elem(src2_q, 0, 0);
              OP_SCI:  acc = elem(src1_q, ri, j) * PW'(signed'(imm_q));
              default: acc = '0;
            endcase
            stage_d[(ri*N + j)*W +: W] = reduce_elem(acc);
          end
        end
        // MULTIPLY steps through columns before rows; other ops step rows only.
        if (op_q == OP_MUL && j_q != IW'(N-1)) begin
          j_d = j_q + IW'(1);
        end else begin
          j_d = '0;
          if (i_q == IW'(N-1)) begin
            i_d      = '0;
            state_d  = DONE;
            result_d = stage_d;
          end else begin
            i_d = i_q + IW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Self-checking bench for matrix_alu_seq (N=4, W=16): directed vector table,
// multi-cycle corner sequences and randomized operations against a model.
module tb_matrix_alu_seq;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MW = N*N*W;

  logic          Clk = 1'b0;
  logic          nReset;
  logic          wr_en, wr_sel, cmd_valid, rd_en;
  logic [MW-1:0] wr_data;
  logic [2:0]    cmd_op;
  logic [W-1:0]  cmd_imm;
  logic          cmd_ready, rd_valid, busy, done, err;
  logic [MW-1:0] rd_data;

  int n_cmp = 0;
  int n_bad = 0;
  logic [MW-1:0] cur_res;

  matrix_alu_seq #(.N(N), .W(W)) dut (
    .Clk(Clk), .nReset(nReset), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_imm(cmd_imm), .cmd_ready(cmd_ready), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .err(err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]    op;
    logic [W-1:0]  imm;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic [MW-1:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] red(input longint v);
    logic [63:0] t;
`ifdef MATRIX_ALU_SAT_EN
    if (v > 32767)  return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    t = 64'(v);
    return t[15:0];
  endfunction

  function automatic longint el(input logic [MW-1:0] m, input int r, input int c);
    logic signed [W-1:0] t;
    t = m[(r*N + c)*W +: W];
    return longint'(t);
  endfunction

  function automatic logic [MW-1:0] model(input logic [2:0] op, input logic [MW-1:0] a,
                                          input logic [MW-1:0] b, input logic [W-1:0] imm);
    logic [MW-1:0] r;
    logic signed [W-1:0] si;
    longint s;
    si = imm;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        case (op)
          3'd0: for (int k = 0; k < N; k++) s += el(a, i, k) * el(b, k, j);
          3'd1: s = el(a, i, j) + el(b, i, j);
          3'd2: s = el(a, i, j) - el(b, i, j);
          3'd3: s = el(a, j, i);
          3'd4: s = el(a, i, j) * el(b, 0, 0);
          default: s = el(a, i, j) * longint'(si);
        endcase
        r[(i*N + j)*W +: W] = red(s);
      end
    return r;
  endfunction

  function automatic logic [MW-1:0] fill(input logic [W-1:0] v);
    logic [MW-1:0] r;
    for (int i = 0; i < N*N; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [MW-1:0] rnd_mat();
    logic [MW-1:0] r;
    for (int i = 0; i < N*N; i++) r[i*W +: W] = 16'($urandom);
    return r;
  endfunction

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic load(input logic sel, input logic [MW-1:0] m);
    wr_en = 1'b1; wr_sel = sel; wr_data = m;
    @(negedge Clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_check(input logic [MW-1:0] exp, input string tag);
    rd_en = 1'b1;
    @(negedge Clk);
    rd_en = 1'b0;
    chk({tag, "_rd_valid"}, 256'(rd_valid), 256'(1));
    chk({tag, "_rd_data"}, rd_data, exp);
    @(negedge Clk);
    chk({tag, "_rd_hold_valid"}, 256'(rd_valid), 256'(0));
    chk({tag, "_rd_hold_data"}, rd_data, exp);
  endtask

  // Issue command (optionally with a same-cycle src1 load); returns at cycle 1 of EXEC.
  task automatic start_op(input logic [2:0] op, input logic [W-1:0] imm,
                          input logic load_too, input logic [MW-1:0] ld, input string tag);
    chk({tag, "_cmd_ready"}, 256'(cmd_ready), 256'(1));
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    if (load_too) begin wr_en = 1'b1; wr_sel = 1'b0; wr_data = ld; end
    @(negedge Clk);
    cmd_valid = 1'b0; wr_en = 1'b0;
    cmd_op = 3'($urandom); cmd_imm = 16'($urandom);
  endtask

  task automatic wait_done(input int cyc0, input int exp_lat, input int exp_busy,
                           input logic [MW-1:0] exp_res, input logic rd_in_done, input string tag);
    int cyc, nb, ne;
    cyc = cyc0; nb = 0; ne = 0;
    while (!done && cyc < 200) begin
      if (busy) nb++;
      if (err) ne++;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = 3'($urandom);
      @(negedge Clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    if (err) ne++;
    chk({tag, "_latency"}, 256'(cyc), 256'(exp_lat));
    chk({tag, "_busy_cycles"}, 256'(nb), 256'(exp_busy));
    chk({tag, "_no_err"}, 256'(ne), 256'(0));
    cur_res = exp_res;
    if (rd_in_done) rd_en = 1'b1;
    @(negedge Clk);
    rd_en = 1'b0;
    chk({tag, "_done_pulse"}, 256'(done), 256'(0));
    chk({tag, "_idle_again"}, 256'(cmd_ready), 256'(1));
    if (rd_in_done) begin
      chk({tag, "_rd_in_done_valid"}, 256'(rd_valid), 256'(1));
      chk({tag, "_rd_in_done_data"}, rd_data, exp_res);
    end else begin
      rd_check(exp_res, tag);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] imm, input logic load_too,
                        input logic [MW-1:0] ld, input logic [MW-1:0] exp_res,
                        input logic rd_in_done, input string tag);
    int lat;
    lat = (op == 3'd0) ? N*N + 1 : N + 1;
    start_op(op, imm, load_too, ld, tag);
    wait_done(1, lat, lat - 1, exp_res, rd_in_done, tag);
  endtask

  initial begin
    logic [MW-1:0] a, b, exp, ramp, ident, trn, scl, junk;
    logic [2:0] op;
    logic [W-1:0] imm;
    logic same_cycle;

    nReset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0;
    cmd_valid = 1'b0; cmd_op = '0; cmd_imm = '0; rd_en = 1'b0;
    cur_res = '0;

    // Directed vectors
    ramp = '0; ident = '0; trn = '0; scl = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ramp[(i*N + j)*W +: W]  = 16'(4*i + j);
        trn[(i*N + j)*W +: W]   = 16'(4*j + i);
        scl[(i*N + j)*W +: W]   = 16'(0 - (4*i + j));
        ident[(i*N + j)*W +: W] = (i == j) ? 16'd1 : 16'd0;
      end
    tbl[0] = '{op: 3'd1, imm: 16'h0, a: fill(16'h0003), b: fill(16'h0002), exp: fill(16'h0005)};
    tbl[1] = '{op: 3'd0, imm: 16'h0, a: ident, b: ramp, exp: ramp};
`ifdef MATRIX_ALU_SAT_EN
    tbl[2] = '{op: 3'd5, imm: 16'h2, a: fill(16'h7FFF), b: ramp, exp: fill(16'h7FFF)};
`else
    tbl[2] = '{op: 3'd5, imm: 16'h2, a: fill(16'h7FFF), b: ramp, exp: fill(16'hFFFE)};
`endif
    tbl[3] = '{op: 3'd3, imm: 16'h0, a: ramp, b: fill(16'h1234), exp: trn};
    tbl[4] = '{op: 3'd2, imm: 16'h0, a: fill(16'h0002), b: fill(16'h0003), exp: fill(16'hFFFF)};
    tbl[5] = '{op: 3'd4, imm: 16'h0, a: ramp, b: 256'(16'hFFFF), exp: scl};

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_rd_valid", 256'(rd_valid), 256'(0));
    chk("rst_rd_data", rd_data, '0);
    nReset = 1'b1;
    @(negedge Clk);
    chk("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    rd_check('0, "rst_read");

    // Vector table
    foreach (tbl[v]) begin
      load(1'b0, tbl[v].a);
      load(1'b1, tbl[v].b);
      run_op(tbl[v].op, tbl[v].imm, 1'b0, '0, tbl[v].exp, v[0], $sformatf("vec%0d", v));
    end

    // wr_en and rd_en during MULTIPLY
    a = rnd_mat(); b = rnd_mat(); junk = rnd_mat();
    load(1'b0, a);
    load(1'b1, b);
    exp = model(3'd0, a, b, 16'h0);
    start_op(3'd0, 16'h0, 1'b0, '0, "exec_wr");
    @(negedge Clk);
    wr_en = 1'b1; wr_sel = 1'b0; wr_data = junk; rd_en = 1'b1;
    @(negedge Clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("exec_wr_err", 256'(err), 256'(1));
    chk("exec_rd_valid", 256'(rd_valid), 256'(1));
    chk("exec_rd_prev", rd_data, cur_res);
    @(negedge Clk);
    chk("exec_err_pulse", 256'(err), 256'(0));
    wait_done(4, N*N + 1, N*N - 3, exp, 1'b0, "exec_wr");
    run_op(3'd1, 16'h0, 1'b0, '0, model(3'd1, a, b, 16'h0), 1'b0, "src_unchanged");

    // Illegal opcode in IDLE
    cmd_valid = 1'b1; cmd_op = 3'd6;
    @(negedge Clk);
    cmd_valid = 1'b0;
    chk("illegal_err", 256'(err), 256'(1));
    chk("illegal_idle", 256'(cmd_ready), 256'(1));
    chk("illegal_not_busy", 256'(busy), 256'(0));
    @(negedge Clk);
    chk("illegal_err_pulse", 256'(err), 256'(0));
    chk("illegal_still_idle", 256'(busy), 256'(0));

    // Randomized operations, some with a same-cycle src1 load
    for (int t = 0; t < 30; t++) begin
      a = rnd_mat(); b = rnd_mat(); junk = rnd_mat();
      op = 3'($urandom_range(0, 5));
      imm = 16'($urandom);
      same_cycle = (t % 4 == 1);
      load(1'b0, a);
      load(1'b1, b);
      exp = model(op, same_cycle ? junk : a, b, imm);
      run_op(op, imm, same_cycle, junk, exp, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_op%0d", t, op));
    end

    // Reset during SUBTRACT
    a = rnd_mat(); b = rnd_mat();
    load(1'b0, a);
    load(1'b1, b);
    start_op(3'd2, 16'h0, 1'b0, '0, "abort");
    @(negedge Clk);
    nReset = 1'b0;
    #1;
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_done", 256'(done), 256'(0));
    chk("abort_err", 256'(err), 256'(0));
    chk("abort_rd_valid", 256'(rd_valid), 256'(0));
    chk("abort_rd_data", rd_data, '0);
    @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    chk("abort_cmd_ready", 256'(cmd_ready), 256'(1));
    rd_check('0, "abort_read");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
